// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM capture blocks: accumulator sizing and the
// mapping of a PDM bit onto a signed sample.
package pdm_pkg;

    // CIC register growth: one sign bit + one magnitude bit for the +/-1 input,
    // plus LOG2R bits per stage.
    function automatic int accWidth(input int order, input int log2r);
        return 2 + order * log2r;
    endfunction

    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

endpackage

// File: rtl/pdm_sync_edge.sv
// Brings an asynchronous PDM bit clock and data pair into the system clock
// domain and flags each rising edge of the bit clock with a one-cycle strobe.
module pdm_sync_edge (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_pdmClk,
    input  logic i_pdmData,
    output logic o_smp,
    output logic o_data
);

    logic [1:0] r_clkSync;
    logic [1:0] r_dataSync;
    logic       r_clkPrev;

    // Clock and data share the same synchroniser depth, so the data bit seen
    // with the strobe is the one that was on the pin at the bit-clock edge.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_clkSync  <= '0;
            r_dataSync <= '0;
            r_clkPrev  <= 1'b0;
        end else begin
            r_clkSync  <= {r_clkSync[0], i_pdmClk};
            r_dataSync <= {r_dataSync[0], i_pdmData};
            r_clkPrev  <= r_clkSync[1];
        end
    end

    assign o_smp  = r_clkSync[1] & ~r_clkPrev;
    assign o_data = r_dataSync[1];

endmodule

// File: rtl/pdm_cic_decim.sv
// PDM to PCM converter: CIC decimator (ORDER integrators, ORDER combs, ratio
// 2**LOG2R) with a valid/ready output register and sticky drop reporting.
module pdm_cic_decim
    import pdm_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int LOG2R = 6,
    parameter int OUT_W = 16
) (
    input  logic             AHBclk,
    input  logic             rst,
    input  logic             en,
    input  logic             pdm_clk_in,
    input  logic             pdm_data_in,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_vld,
    input  logic             pcm_rdy,
    output logic             ovf,
    output logic             bsy
);

    localparam int ACC_W = accWidth(ORDER, LOG2R);

    logic             w_smp;
    logic             w_bit;
    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_integOut;
    logic [ACC_W-1:0] w_combOut;
    logic [OUT_W-1:0] w_pcmNext;
    logic [LOG2R-1:0] r_decCnt;
    logic             r_decStb;

    pdm_sync_edge u_syncEdge (
        .i_clk     (AHBclk),
        .i_rstN    (rst),
        .i_pdmClk  (pdm_clk_in),
        .i_pdmData (pdm_data_in),
        .o_smp     (w_smp),
        .o_data    (w_bit)
    );

    assign w_x = w_bit ? ACC_W'(PDM_POS) : ACC_W'(PDM_NEG);

    // Each integrator adds the previous stage's value from before this update,
    // so the cascade is effectively pipelined by one sample per stage.
    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic [ACC_W-1:0] w_in;
        logic [ACC_W-1:0] r_acc;

        if (k == 0) begin : g_src
            assign w_in = w_x;
        end else begin : g_src
            assign w_in = g_integ[k-1].r_acc;
        end

        always_ff @(posedge AHBclk) begin
            if (!rst || !en) begin
                r_acc <= '0;
            end else if (w_smp) begin
                r_acc <= r_acc + w_in;
            end
        end
    end

    assign w_integOut = g_integ[ORDER-1].r_acc;

    always_ff @(posedge AHBclk) begin
        if (!rst || !en) begin
            r_decCnt <= '0;
            r_decStb <= 1'b0;
        end else begin
            r_decStb <= 1'b0;
            if (w_smp) begin
                r_decCnt <= r_decCnt + LOG2R'(1);
                if (&r_decCnt) begin
                    r_decStb <= 1'b1;
                end
            end
        end
    end

    // Combs are evaluated combinationally across all stages in the dec_stb
    // cycle; only the delay elements and the output register hold state.
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic [ACC_W-1:0] w_in;
        logic [ACC_W-1:0] w_out;
        logic [ACC_W-1:0] r_dly;

        if (k == 0) begin : g_src
            assign w_in = w_integOut;
        end else begin : g_src
            assign w_in = g_comb[k-1].w_out;
        end

        assign w_out = w_in - r_dly;

        always_ff @(posedge AHBclk) begin
            if (!rst || !en) begin
                r_dly <= '0;
            end else if (r_decStb) begin
                r_dly <= w_in;
            end
        end
    end

    assign w_combOut = g_comb[ORDER-1].w_out;

    // Full scale of +/-2**(ACC_W-2) lands on +/-2**(OUT_W-2): no saturation,
    // one bit of headroom left in the PCM word.
    assign w_pcmNext = OUT_W'(w_combOut >> (ACC_W - OUT_W));

    always_ff @(posedge AHBclk) begin
        if (!rst || !en) begin
            pcm_data <= '0;
            pcm_vld  <= 1'b0;
            ovf      <= 1'b0;
        end else if (r_decStb) begin
            if (pcm_vld && !pcm_rdy) begin
                ovf <= 1'b1;
            end else begin
                pcm_data <= w_pcmNext;
                pcm_vld  <= 1'b1;
            end
        end else if (pcm_rdy) begin
            pcm_vld <= 1'b0;
        end
    end

    always_ff @(posedge AHBclk) begin
        if (!rst) begin
            bsy <= 1'b0;
        end else begin
            bsy <= en;
        end
    end

endmodule
